sdram_arbit: RTL and testbench

SDRAM command arbiter, directly downstream of the SDRAM power-up initialisation stage. While initialisation runs, it passes the initialisation command and address through to the SDRAM pins. Once `flag_init` is high, it owns the SDRAM command bus and grants it to three clients: an internal auto-refresh sequencer, the write engine and the read engine. Priority is refresh, then write, then read.

---
 rtl/sdram_pkg.sv | 29 ++
 rtl/sdram_aref.sv | 109 ++++++++++
 rtl/sdram_arbit.sv | 124 ++++++++++++
 tb/tb_sdram_arbit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// ----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM controller slice. The init stage, the
// read and write engines and the arbiter all use these.
//   - Five-bit SDRAM commands, encoded {CKE,CS,RAS,CAS,WE}
//   - Address used by PRECHARGE to close all banks (A10 high)
//   - Arbiter state encoding
// ----------------------------------------------------------------------------
package sdram_pkg;

    localparam logic [4:0]  CMD_NOP  = 5'b10111;
    localparam logic [4:0]  CMD_PREC = 5'b10010;
    localparam logic [4:0]  CMD_AREF = 5'b10001;
    localparam logic [4:0]  CMD_MRS  = 5'b10000;
    localparam logic [4:0]  CMD_ACT  = 5'b10011;
    localparam logic [4:0]  CMD_RD   = 5'b10101;
    localparam logic [4:0]  CMD_WR   = 5'b10100;

    localparam logic [11:0] ADDR_PREC_ALL = 12'h400;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/sdram_aref.sv
// ----------------------------------------------------------------------------
// sdram_aref
// Auto-refresh timer and refresh command sequencer.
//   S_CLK, RST_N  : clock, asynchronous active-low reset
//   timer_en      : timer counts while high, is held at 0 while low
//   start         : one-cycle pulse, arbiter is entering the refresh state
//   ref_pending   : a refresh interval has elapsed and no refresh has started
//   ref_cmd/addr  : command and address for the current refresh step
//   ref_end       : high on the last step of the refresh sequence
// ----------------------------------------------------------------------------
module sdram_aref
    import sdram_pkg::*;
#(
    parameter int REF_CYCLES = 300,
    parameter int REF_LEN    = 6
) (
    input  logic        S_CLK,
    input  logic        RST_N,
    input  logic        timer_en,
    input  logic        start,
    output logic        ref_pending,
    output logic [4:0]  ref_cmd,
    output logic [11:0] ref_addr,
    output logic        ref_end
);

    localparam int CW = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
    localparam int SW = (REF_LEN > 1) ? $clog2(REF_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REF_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(REF_LEN - 1);

    logic [CW-1:0] cnt_q,  cnt_d;
    logic          pend_q, pend_d;
    logic          busy_q, busy_d;
    logic [SW-1:0] step_q, step_d;
    logic          fire;

    assign fire = timer_en && (cnt_q == CNT_LAST);

    // Timer wraps on its own; it never waits for the refresh to be served,
    // so the refresh period stays fixed regardless of bus load.
    always_comb begin
        cnt_d = cnt_q;
        if (!timer_en)
            cnt_d = '0;
        else if (cnt_q == CNT_LAST)
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;
    end

    // A new expiry wins over the clear so a refresh is never lost.
    always_comb begin
        pend_d = pend_q;
        if (fire)
            pend_d = 1'b1;
        else if (start)
            pend_d = 1'b0;
    end

    always_comb begin
        busy_d = busy_q;
        step_d = step_q;
        if (start) begin
            busy_d = 1'b1;
            step_d = '0;
        end else if (busy_q) begin
            if (step_q == STEP_LAST) begin
                busy_d = 1'b0;
                step_d = '0;
            end else begin
                step_d = step_q + 1'b1;
            end
        end
    end

    always_ff @(posedge S_CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            busy_q <= 1'b0;
            step_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
            step_q <= step_d;
        end
    end

    // Step 0 closes all banks, step 2 issues the refresh; the remaining
    // steps are NOPs covering tRP / tRFC.
    always_comb begin
        ref_cmd  = CMD_NOP;
        ref_addr = '0;
        if (busy_q) begin
            if (step_q == SW'(0)) begin
                ref_cmd  = CMD_PREC;
                ref_addr = ADDR_PREC_ALL;
            end else if (step_q == SW'(2)) begin
                ref_cmd  = CMD_AREF;
            end
        end
    end

    assign ref_pending = pend_q;
    assign ref_end     = busy_q && (step_q == STEP_LAST);

endmodule

// File: rtl/sdram_arbit.sv
// ----------------------------------------------------------------------------
// sdram_arbit
// SDRAM command bus arbiter. Passes the init stage through until flag_init,
// then grants the bus to refresh, write and read in that priority order.
//   S_CLK, RST_N          : clock, asynchronous active-low reset
//   init_cmd/init_addr    : command/address from the init stage
//   flag_init             : init complete (sticky)
//   wr_req/cmd/addr/end   : write engine request, bus drive, last-cycle pulse
//   wr_en                 : write grant
//   rd_*                  : same for the read engine
//   aref_pending          : refresh due, engines should wrap up their burst
//   sdram_cmd/sdram_addr  : SDRAM pins
// ----------------------------------------------------------------------------
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int REF_CYCLES = 300,
    parameter int REF_LEN    = 6
) (
    input  logic        S_CLK,
    input  logic        RST_N,
    input  logic [4:0]  init_cmd,
    input  logic [11:0] init_addr,
    input  logic        flag_init,
    input  logic        wr_req,
    input  logic [4:0]  wr_cmd,
    input  logic [11:0] wr_addr,
    input  logic        wr_end,
    output logic        wr_en,
    input  logic        rd_req,
    input  logic [4:0]  rd_cmd,
    input  logic [11:0] rd_addr,
    input  logic        rd_end,
    output logic        rd_en,
    output logic        aref_pending,
    output logic [4:0]  sdram_cmd,
    output logic [11:0] sdram_addr
);

    arb_state_e  state_q, state_d;
    logic        ref_pending;
    logic [4:0]  ref_cmd;
    logic [11:0] ref_addr;
    logic        ref_end;
    logic        ref_start;
    logic        timer_en;

    // The refresh sequencer starts on the same edge the FSM enters AREF,
    // so its step counter reads 0 in the first AREF cycle.
    assign ref_start = (state_q == ST_ARBIT) && ref_pending;
    assign timer_en  = (state_q != ST_INIT);

    sdram_aref #(
        .REF_CYCLES (REF_CYCLES),
        .REF_LEN    (REF_LEN)
    ) u_aref (
        .S_CLK       (S_CLK),
        .RST_N       (RST_N),
        .timer_en    (timer_en),
        .start       (ref_start),
        .ref_pending (ref_pending),
        .ref_cmd     (ref_cmd),
        .ref_addr    (ref_addr),
        .ref_end     (ref_end)
    );

    always_ff @(posedge S_CLK or negedge RST_N) begin
        if (!RST_N)
            state_q <= ST_INIT;
        else
            state_q <= state_d;
    end

    // Grants are never preempted: a refresh that comes due mid-burst waits
    // for the engine's end pulse and is then picked first in ARBIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (flag_init) state_d = ST_ARBIT;
            ST_ARBIT: begin
                if (ref_pending)  state_d = ST_AREF;
                else if (wr_req)  state_d = ST_WRITE;
                else if (rd_req)  state_d = ST_READ;
            end
            ST_AREF:  if (ref_end) state_d = ST_ARBIT;
            ST_WRITE: if (wr_end)  state_d = ST_ARBIT;
            ST_READ:  if (rd_end)  state_d = ST_ARBIT;
            default:  state_d = ST_INIT;
        endcase
    end

    // Output mux is purely combinational from state so pass-through and
    // grants carry no extra latency and drop the instant reset asserts.
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        case (state_q)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = ref_cmd;
                sdram_addr = ref_addr;
            end
            ST_WRITE: begin
                wr_en      = 1'b1;
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
            end
            ST_READ: begin
                rd_en      = 1'b1;
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign aref_pending = ref_pending;

endmodule

// File: tb/tb_sdram_arbit.sv
module tb_sdram_arbit;
    import sdram_pkg::*;

    localparam int RC = 300;
    localparam int RL = 6;

    logic        S_CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [4:0]  init_cmd = CMD_NOP;
    logic [11:0] init_addr = '0;
    logic        flag_init = 1'b0;
    logic        wr_req = 1'b0, wr_end = 1'b0, rd_req = 1'b0, rd_end = 1'b0;
    logic [4:0]  wr_cmd = CMD_NOP, rd_cmd = CMD_NOP;
    logic [11:0] wr_addr = '0, rd_addr = '0;
    logic        wr_en, rd_en, aref_pending;
    logic [4:0]  sdram_cmd;
    logic [11:0] sdram_addr;

    sdram_arbit #(.REF_CYCLES(RC), .REF_LEN(RL)) dut (
        .S_CLK(S_CLK), .RST_N(RST_N),
        .init_cmd(init_cmd), .init_addr(init_addr), .flag_init(flag_init),
        .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_end(wr_end), .wr_en(wr_en),
        .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_end(rd_end), .rd_en(rd_en),
        .aref_pending(aref_pending), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr)
    );

    always #5 S_CLK = ~S_CLK;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [4:0]  icmd;
        logic [11:0] iaddr;
        logic        flag;
        logic [4:0]  ecmd;
        logic [11:0] eaddr;
        logic        arbit;
    } pt_vec_t;

    pt_vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge S_CLK);
        #1;
        cyc++;
    endtask

    task automatic idle_to(input int n);
        while (cyc < n) tick();
    endtask

    // Whole bus view in one word: {cmd, addr, aref_pending, wr_en, rd_en}.
    function automatic logic [31:0] bus(input logic [4:0] c, input logic [11:0] a,
                                        input logic p, input logic w, input logic r);
        return {12'd0, c, a, p, w, r};
    endfunction

    // Idle expectation, k cycles after the first ARBIT cycle.
    function automatic logic [31:0] idle_exp(input int k);
        logic [4:0]  c = CMD_NOP;
        logic [11:0] a = 12'h000;
        logic        p = (k > 0) && (k % RC == 0);
        if (k > 1 && k % RC == 1) begin c = CMD_PREC; a = 12'h400; end
        if (k > 3 && k % RC == 3) c = CMD_AREF;
        return bus(c, a, p, 1'b0, 1'b0);
    endfunction

    task automatic idle_run(input string name, input int last);
        for (int k = 1; k <= last; k++) begin
            tick();
            #1;
            chk(name, bus(sdram_cmd, sdram_addr, aref_pending, wr_en, rd_en), idle_exp(cyc));
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        #2;
        chk("rst_cmd",  32'(sdram_cmd), 32'(CMD_NOP));
        chk("rst_addr", 32'(sdram_addr), 32'h0);
        chk("rst_grants", {29'd0, aref_pending, wr_en, rd_en}, 32'h0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_INIT));
        init_cmd = CMD_PREC; init_addr = 12'h400;
        #1;
        chk("rst_passthru", {15'd0, sdram_cmd, sdram_addr}, {15'd0, CMD_PREC, 12'h400});
        #10 RST_N = 1'b1;
        tick();

        // ---------------- pass-through table ----------------
        vt[0] = '{CMD_PREC, 12'h400, 1'b0, CMD_PREC, 12'h400, 1'b0};
        vt[1] = '{CMD_NOP,  12'h000, 1'b0, CMD_NOP,  12'h000, 1'b0};
        vt[2] = '{CMD_AREF, 12'h000, 1'b0, CMD_AREF, 12'h000, 1'b0};
        vt[3] = '{CMD_MRS,  12'h422, 1'b0, CMD_MRS,  12'h422, 1'b0};
        vt[4] = '{CMD_NOP,  12'h000, 1'b1, CMD_NOP,  12'h000, 1'b0};
        vt[5] = '{CMD_MRS,  12'h422, 1'b1, CMD_NOP,  12'h000, 1'b1};
        for (int i = 0; i < 6; i++) begin
            init_cmd = vt[i].icmd; init_addr = vt[i].iaddr; flag_init = vt[i].flag;
            #1;
            chk($sformatf("pt%0d_bus", i), {15'd0, sdram_cmd, sdram_addr}, {15'd0, vt[i].ecmd, vt[i].eaddr});
            chk($sformatf("pt%0d_state", i), 32'(dut.state_q),
                vt[i].arbit ? 32'(ST_ARBIT) : 32'(ST_INIT));
            if (i < 5) tick();
        end
        init_cmd = CMD_NOP; init_addr = '0;
        cyc = 0;   // first ARBIT cycle

        // ---------------- idle refresh, two periods ----------------
        idle_run("idle_ref", 2 * RC + 7);

        // ---------------- simultaneous requests ----------------
        idle_to(620);
        wr_req = 1; rd_req = 1;
        wr_cmd = CMD_ACT; wr_addr = 12'h123; rd_cmd = CMD_ACT; rd_addr = 12'h055;
        #1 chk("sim_arbit", bus(sdram_cmd, sdram_addr, aref_pending, wr_en, rd_en),
               bus(CMD_NOP, 12'h0, 1'b0, 1'b0, 1'b0));
        tick(); #1;
        chk("sim_wgrant", bus(sdram_cmd, sdram_addr, aref_pending, wr_en, rd_en),
            bus(CMD_ACT, 12'h123, 1'b0, 1'b1, 1'b0));
        wr_req = 0; wr_cmd = CMD_WR; wr_addr = 12'h010; rd_end = 1;   // stray rd_end
        tick(); #1;
        chk("sim_wstay", bus(sdram_cmd, sdram_addr, aref_pending, wr_en, rd_en),
            bus(CMD_WR, 12'h010, 1'b0, 1'b1, 1'b0));
        rd_end = 0; wr_end = 1;
        tick(); wr_end = 0; #1;
        chk("sim_gap", bus(sdram_cmd, sdram_addr, aref_pending, wr_en, rd_en),
            bus(CMD_NOP, 12'h0, 1'b0, 1'b0, 1'b0));
        tick(); #1;
        chk("sim_rgrant", bus(sdram_cmd, sdram_addr, aref_pending, wr_en, rd_en),
            bus(CMD_ACT, 12'h055, 1'b0, 1'b0, 1'b1));
        rd_req = 0; wr_end = 1;   // stray wr_end
        tick(); wr_end = 0; #1;
        chk("sim_rstay", 32'(rd_en), 32'h1);
        rd_end = 1;
        tick(); rd_end = 0; #1;
        chk("sim_rdone", bus(sdram_cmd, sdram_addr, aref_pending, wr_en, rd_en),
            bus(CMD_NOP, 12'h0, 1'b0, 1'b0, 1'b0));

        // ---------------- refresh due during a write ----------------
        idle_to(895);
        wr_req = 1; wr_cmd = CMD_WR; wr_addr = 12'h200;
        tick();
        wr_req = 0; rd_req = 1; rd_cmd = CMD_RD; rd_addr = 12'h033;
        while (cyc <= 905) begin
            #1;
            chk("rw_hold", {30'd0, aref_pending, wr_en}, {30'd0, (cyc >= 900), 1'b1});
            if (cyc == 905) wr_end = 1;
            tick();
        end
        wr_end = 0; #1;
        chk("rw_arbit", bus(sdram_cmd, sdram_addr, aref_pending, wr_en, rd_en),
            bus(CMD_NOP, 12'h0, 1'b1, 1'b0, 1'b0));
        tick(); #1;
        chk("rw_prec", bus(sdram_cmd, sdram_addr, aref_pending, wr_en, rd_en),
            bus(CMD_PREC, 12'h400, 1'b0, 1'b0, 1'b0));
        tick(); #1;
        chk("rw_nop1", 32'(sdram_cmd), 32'(CMD_NOP));
        tick(); #1;
        chk("rw_aref", bus(sdram_cmd, sdram_addr, aref_pending, wr_en, rd_en),
            bus(CMD_AREF, 12'h0, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 4; k++) begin   // cycles 910..913
            tick(); #1;
            chk("rw_tail", bus(sdram_cmd, sdram_addr, aref_pending, wr_en, rd_en),
                bus(CMD_NOP, 12'h0, 1'b0, 1'b0, 1'b0));
        end
        tick(); #1;
        chk("rw_rgrant", bus(sdram_cmd, sdram_addr, aref_pending, wr_en, rd_en),
            bus(CMD_RD, 12'h033, 1'b0, 1'b0, 1'b1));
        rd_req = 0;

        // ---------------- reset mid-READ ----------------
        RST_N = 0; flag_init = 0; init_cmd = CMD_MRS; init_addr = 12'h422;
        #1;
        chk("mr_grant", {30'd0, rd_en, wr_en}, 32'h0);
        chk("mr_state", 32'(dut.state_q), 32'(ST_INIT));
        chk("mr_bus", {15'd0, sdram_cmd, sdram_addr}, {15'd0, CMD_MRS, 12'h422});
        chk("mr_pend", 32'(aref_pending), 32'h0);
        #1 RST_N = 1;
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            chk("mr_hold", {12'd0, 3'(dut.state_q), sdram_cmd, sdram_addr},
                {12'd0, 3'(ST_INIT), CMD_MRS, 12'h422});
        end
        flag_init = 1; init_cmd = CMD_NOP; init_addr = '0;
        tick(); #1;
        chk("mr_arbit", 32'(dut.state_q), 32'(ST_ARBIT));
        cyc = 0;
        idle_run("mr_ref", RC + 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
